// File: rtl/glyph_row_shifter_if.sv
// ---------------------------------------------------------------------------
// glyph_row_shifter_if
//   Bundles the row-load / shift handshake and the serial pixel outputs of
//   the glyph row shifter.
//
//   Signals:
//     data_in         [WIDTH]  parallel glyph row to load
//     data_in_enable  [1]      parallel load strobe
//     shift_enable    [1]      shift strobe (may be tied high)
//     data_out        [1]      current pixel bit (1 = foreground)
//     bits_remaining  [CW]     loaded bits not yet shifted out
//     empty           [1]      bits_remaining == 0
//
//   Modports:
//     master : pixel generator side (drives strobes and data)
//     slave  : shifter side (drives the pixel outputs)
// ---------------------------------------------------------------------------
interface glyph_row_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] data_in;
    logic             data_in_enable;
    logic             shift_enable;
    logic             data_out;
    logic [CW-1:0]    bits_remaining;
    logic             empty;

    modport master (
        output data_in,
        output data_in_enable,
        output shift_enable,
        input  data_out,
        input  bits_remaining,
        input  empty
    );

    modport slave (
        input  data_in,
        input  data_in_enable,
        input  shift_enable,
        output data_out,
        output bits_remaining,
        output empty
    );
endinterface

// File: rtl/glyph_row_shifter.sv
// ---------------------------------------------------------------------------
// glyph_row_shifter
//   Parallel-load, serial-out shift register that turns one font bitmap row
//   into one pixel bit per clock for the text-mode video pipeline.
//
//   Parameters:
//     WIDTH     glyph width in bits, 2..32
//     MSB_FIRST 1: bit WIDTH-1 (leftmost pixel) leaves first; 0: bit 0 first
//     FILL_BIT  value entering the vacated end on every shift
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  glyph_row_shifter_if.slave (load/shift strobes in, pixel out)
//
//   Per-edge priority: rst > load > shift > hold. All outputs come straight
//   from registers, so there is no combinational input-to-output path.
// ---------------------------------------------------------------------------
module glyph_row_shifter #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit FILL_BIT  = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    glyph_row_shifter_if.slave  bus
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LOAD_CNT = CW'(WIDTH);

    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_shifted;
    logic             w_out_bit;

    // Shift direction is fixed at elaboration; the output tap sits at the
    // end the bits leave from, the fill bit enters at the opposite end.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_shreg[WIDTH-2:0], 1'(FILL_BIT)};
            assign w_out_bit = r_shreg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'(FILL_BIT), r_shreg[WIDTH-1:1]};
            assign w_out_bit = r_shreg[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (bus.data_in_enable) begin
            // A load overrides any shift in the same cycle and silently
            // replaces whatever bits were still pending.
            r_shreg <= bus.data_in;
            r_count <= LOAD_CNT;
        end else if (bus.shift_enable) begin
            // Shifting while drained is legal: fill bits keep flowing and
            // the count saturates at zero.
            r_shreg <= w_shifted;
            if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign bus.data_out       = w_out_bit;
    assign bus.bits_remaining = r_count;
    assign bus.empty          = (r_count == '0);
endmodule

// File: tb/tb_glyph_row_shifter.sv
// ---------------------------------------------------------------------------
// tb_glyph_row_shifter
//   Drives an MSB-first and an LSB-first shifter with identical stimulus and
//   compares both against a pixel-order list model after every clock edge.
//   Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_glyph_row_shifter;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    glyph_row_shifter_if #(.WIDTH(W)) m_if ();
    glyph_row_shifter_if #(.WIDTH(W)) l_if ();

    glyph_row_shifter #(.WIDTH(W), .MSB_FIRST(1'b1), .FILL_BIT(1'b0)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    glyph_row_shifter #(.WIDTH(W), .MSB_FIRST(1'b0), .FILL_BIT(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (l_if)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: for each variant, the pixels still to appear, in display order.
    // Slot 0 is the pixel on data_out now; drained slots hold the fill bit.
    bit pix [2][W];
    int cnt [2];

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit ld, input logic [W-1:0] d, input bit sh);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                for (int i = 0; i < W; i++) pix[k][i] = 1'b0;
                cnt[k] = 0;
            end else if (ld) begin
                // k=0 shows the leftmost (highest) bit first, k=1 bit 0 first
                for (int i = 0; i < W; i++) pix[k][i] = (k == 0) ? d[W-1-i] : d[i];
                cnt[k] = W;
            end else if (sh) begin
                for (int i = 0; i < W-1; i++) pix[k][i] = pix[k][i+1];
                pix[k][W-1] = 1'b0;
                cnt[k] = (cnt[k] > 0) ? cnt[k] - 1 : 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("msb_out",   int'(m_if.data_out),       int'(pix[0][0]));
        chk("msb_rem",   int'(m_if.bits_remaining), cnt[0]);
        chk("msb_empty", int'(m_if.empty),          int'(cnt[0] == 0));
        chk("lsb_out",   int'(l_if.data_out),       int'(pix[1][0]));
        chk("lsb_rem",   int'(l_if.bits_remaining), cnt[1]);
        chk("lsb_empty", int'(l_if.empty),          int'(cnt[1] == 0));
    endtask

    // One clock: apply inputs, take the edge, advance the model, check #1 later.
    task automatic step(input bit r, input bit ld, input logic [W-1:0] d, input bit sh);
        rst = r;
        m_if.data_in_enable = ld; m_if.data_in = d; m_if.shift_enable = sh;
        l_if.data_in_enable = ld; l_if.data_in = d; l_if.shift_enable = sh;
        @(posedge clk);
        model_update(r, ld, d, sh);
        #1;
        compare_all();
    endtask

    logic [W-1:0] pat;

    initial begin
        m_if.data_in = '0; m_if.data_in_enable = 1'b0; m_if.shift_enable = 1'b0;
        l_if.data_in = '0; l_if.data_in_enable = 1'b0; l_if.shift_enable = 1'b0;

        // Reset held two cycles while a load of all ones is offered
        step(1, 1, 8'hFF, 0);
        step(1, 1, 8'hFF, 0);
        chk("rst_out", int'(m_if.data_out), 0);
        chk("rst_empty", int'(m_if.empty), 1);
        step(0, 0, 8'h00, 0);
        chk("rel_rem", int'(m_if.bits_remaining), 0);

        // Load then shift out 10110010
        pat = 8'b10110010;
        step(0, 1, pat, 0);
        chk("ld_out0", int'(m_if.data_out), int'(pat[7]));
        chk("ld_rem0", int'(m_if.bits_remaining), 8);
        for (int s = 1; s <= 8; s++) begin
            step(0, 0, 8'h00, 1);
            chk("sh_out", int'(m_if.data_out), (s < 8) ? int'(pat[7-s]) : 0);
            chk("sh_rem", int'(m_if.bits_remaining), 8 - s);
        end
        chk("sh_empty", int'(m_if.empty), 1);
        step(0, 0, 8'h00, 1);
        chk("drain_out", int'(m_if.data_out), 0);
        chk("drain_rem", int'(m_if.bits_remaining), 0);

        // Load/shift collision: reload 3C after four bits of A5
        step(0, 1, 8'hA5, 1);
        for (int s = 0; s < 3; s++) step(0, 0, 8'h00, 1);
        chk("col_bit3", int'(m_if.data_out), 0);
        step(0, 1, 8'h3C, 1);
        chk("col_out", int'(m_if.data_out), 0);
        chk("col_rem", int'(m_if.bits_remaining), 8);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        chk("col_bit2", int'(m_if.data_out), 1);

        // Hold
        step(0, 1, 8'h80, 0);
        for (int s = 0; s < 5; s++) begin
            step(0, 0, 8'h00, 0);
            chk("hold_out", int'(m_if.data_out), 1);
            chk("hold_rem", int'(m_if.bits_remaining), 8);
        end
        step(0, 0, 8'h00, 1);
        chk("resume_out", int'(m_if.data_out), 0);

        // Continuous row: F0/0F alternating, gapless, never empty
        for (int c = 0; c < 6; c++) begin
            pat = (c % 2 == 0) ? 8'hF0 : 8'h0F;
            for (int s = 0; s < 8; s++) begin
                step(0, (s == 0), pat, 1);
                chk("row_out", int'(m_if.data_out), int'(pat[7-s]));
                chk("row_empty", int'(m_if.empty), 0);
            end
        end

        // Reset mid-stream
        step(0, 1, 8'hFF, 0);
        for (int s = 0; s < 3; s++) step(0, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        chk("mrst_out", int'(m_if.data_out), 0);
        chk("mrst_empty", int'(m_if.empty), 1);
        step(0, 0, 8'h00, 0);

        // LSB-first variant: 00000110 -> 0,1,1,0,0,0,0,0
        pat = 8'b00000110;
        step(0, 1, pat, 0);
        chk("lsb_b0", int'(l_if.data_out), 0);
        for (int s = 1; s < 8; s++) begin
            step(0, 0, 8'h00, 1);
            chk("lsb_bit", int'(l_if.data_out), (s == 1 || s == 2) ? 1 : 0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 15),
                 W'($urandom),
                 ($urandom_range(0, 99) < 70));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Safety net so the run always ends on its own
    initial begin
        #2000000;
        n_err++;
        $display("FAIL timeout: got 0 expected 1 (run completion)");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
